// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - handshaken memory-access sequencer (word/byte, indirect, timeout)
module mem_access_unit #(
   parameter int WIDTH    = 16,
   parameter int MAX_WAIT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic               req_indirect,
   input  logic               req_sext,
   input  logic [WIDTH-1:0]   req_addr,
   input  logic [WIDTH-1:0]   req_wdata,
   output logic               rsp_valid,
   output logic [WIDTH-1:0]   rsp_rdata,
   output logic               rsp_error,
   output logic [WIDTH-1:0]   mem_address,
   output logic [WIDTH-1:0]   mem_wdata,
   input  logic [WIDTH-1:0]   mem_rdata,
   output logic               mem_read,
   output logic               mem_write,
   output logic [WIDTH/8-1:0] mem_byte_enable,
   input  logic               mem_resp
);
   localparam int L   = WIDTH / 8;
   localparam int OFF = $clog2(L);
   localparam int CW  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PTR    = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   // op[0]: store, op[1]: byte
   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             sext_q, sext_d;
   logic [WIDTH-1:0] mar_q, mar_d;
   logic [WIDTH-1:0] mdr_q, mdr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic             rsp_error_q, rsp_error_d;
   logic [WIDTH-1:0] mem_address_q, mem_address_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic [L-1:0]     mem_be_q, mem_be_d;

   logic             timeout;
   logic             req_misaligned;
   logic             ptr_misaligned;
   logic [7:0]       load_byte;
   logic [WIDTH-1:0] load_data;
   logic             go_access;
   logic [WIDTH-1:0] acc_addr;
   logic [WIDTH-1:0] acc_wdata;
   logic [1:0]       acc_op;

   assign timeout        = (MAX_WAIT != 0) && ((cnt_q + CW'(1)) == MAX_CNT);
   assign req_misaligned = (req_addr[OFF-1:0] != '0) && (!req_op[1] || req_indirect);
   assign ptr_misaligned = (mem_rdata[OFF-1:0] != '0) && !op_q[1];
   assign load_byte      = 8'(mem_rdata >> {mar_q[OFF-1:0], 3'b000});
   assign load_data      = !op_q[1] ? mem_rdata :
                           sext_q   ? {{(WIDTH-8){load_byte[7]}}, load_byte} :
                                      {{(WIDTH-8){1'b0}}, load_byte};

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      sext_d        = sext_q;
      mar_d         = mar_q;
      mdr_d         = mdr_q;
      cnt_d         = cnt_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_error_d   = rsp_error_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_be_d      = mem_be_q;
      go_access     = 1'b0;
      acc_addr      = mar_q;
      acc_op        = op_q;
      acc_wdata     = mdr_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d   = req_op;
               sext_d = req_sext;
               mar_d  = req_addr;
               mdr_d  = req_wdata;
               if (req_misaligned) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
                  rsp_rdata_d = '0;
               end else if (req_indirect) begin
                  state_d       = S_PTR;
                  cnt_d         = '0;
                  mem_read_d    = 1'b1;
                  mem_address_d = {req_addr[WIDTH-1:OFF], {OFF{1'b0}}};
                  mem_be_d      = '1;
               end else begin
                  go_access = 1'b1;
                  acc_addr  = req_addr;
                  acc_op    = req_op;
                  acc_wdata = req_wdata;
               end
            end
         end
         S_PTR, S_ACCESS: begin
            if (mem_resp && state_q == S_PTR && !ptr_misaligned) begin
               go_access = 1'b1;
               acc_addr  = mem_rdata;
            end else if (mem_resp || timeout) begin
               // Response wins over a timeout landing on the same cycle
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_error_d = !mem_resp || state_q == S_PTR;
               rsp_rdata_d = (mem_resp && state_q == S_ACCESS && !op_q[0]) ? load_data : '0;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               mem_be_d    = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (go_access) begin
         state_d       = S_ACCESS;
         cnt_d         = '0;
         mar_d         = acc_addr;
         mem_address_d = {acc_addr[WIDTH-1:OFF], {OFF{1'b0}}};
         mem_read_d    = !acc_op[0];
         mem_write_d   = acc_op[0];
         mem_wdata_d   = acc_op[1] ? {L{acc_wdata[7:0]}} : acc_wdata;
         mem_be_d      = (acc_op == 2'b11) ? (L'(1) << acc_addr[OFF-1:0]) : '1;
      end

      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         sext_q        <= 1'b0;
         mar_q         <= '0;
         mdr_q         <= '0;
         cnt_q         <= '0;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_error_q   <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_be_q      <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         sext_q        <= sext_d;
         mar_q         <= mar_d;
         mdr_q         <= mdr_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_error_q   <= rsp_error_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_be_q      <= mem_be_d;
      end
   end

   assign req_ready       = req_ready_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_error       = rsp_error_q;
   assign mem_address     = mem_address_q;
   assign mem_wdata       = mem_wdata_q;
   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_byte_enable = mem_be_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (WIDTH=16, MAX_WAIT=4)
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic        req_indirect;
   logic        req_sext;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_error;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic        mem_resp;

   mem_access_unit #(.WIDTH(16), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_indirect(req_indirect), .req_sext(req_sext),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      bit          ind;
      bit          sext;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] d0;
      int          w0;
      logic [15:0] d1;
      int          w1;
      bit          no_resp;
      bit          chk;
      logic [15:0] xaddr;
      logic [15:0] xwdata;
      logic [1:0]  xbe;
      logic [15:0] xrdata;
      bit          xerr;
      int          xlat;
      int          xstrobes;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] rdata;
      bit          err;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   function automatic vec_t mk(string name, logic [1:0] op, bit ind, bit sext,
                               logic [15:0] addr, logic [15:0] wdata,
                               logic [15:0] d0, int w0, logic [15:0] d1, int w1,
                               bit no_resp, bit chk_data, logic [15:0] xaddr,
                               logic [15:0] xwdata, logic [1:0] xbe,
                               logic [15:0] xrdata, bit xerr, int xlat, int xs);
      vec_t v;
      v.name = name; v.op = op; v.ind = ind; v.sext = sext; v.addr = addr;
      v.wdata = wdata; v.d0 = d0; v.w0 = w0; v.d1 = d1; v.w1 = w1;
      v.no_resp = no_resp; v.chk = chk_data; v.xaddr = xaddr; v.xwdata = xwdata;
      v.xbe = xbe; v.xrdata = xrdata; v.xerr = xerr; v.xlat = xlat; v.xstrobes = xs;
      return v;
   endfunction

   // Response monitor: every rsp_valid pulse is matched against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, "_rdata"}, {16'h0, rsp_rdata}, {16'h0, e.rdata});
            chk({e.name, "_error"}, {31'h0, rsp_error}, {31'h0, e.err});
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int   lat, strobes, phase, pcyc, dphase, guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({v.name, "_ready"}, {31'h0, req_ready}, 32'd1);
      req_valid = 1'b1; req_op = v.op; req_indirect = v.ind; req_sext = v.sext;
      req_addr = v.addr; req_wdata = v.wdata;
      e.name = v.name; e.rdata = v.xrdata; e.err = v.xerr;
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; strobes = 0; phase = 0; pcyc = 0;
      dphase = v.ind ? 1 : 0;
      forever begin
         @(negedge clk);
         lat++;
         if (mem_read || mem_write) begin
            strobes++;
            pcyc++;
            if (phase == 0 && v.ind && pcyc == 1) begin
               chk({v.name, "_ptr_addr"}, {16'h0, mem_address}, {16'h0, v.addr & 16'hFFFE});
               chk({v.name, "_ptr_rd"}, {30'h0, mem_read, mem_write}, 32'd2);
            end
            if (phase == dphase && pcyc == 1 && v.chk) begin
               chk({v.name, "_addr"}, {16'h0, mem_address}, {16'h0, v.xaddr});
               chk({v.name, "_rdwr"}, {30'h0, mem_read, mem_write},
                   v.op[0] ? 32'd1 : 32'd2);
               chk({v.name, "_be"}, {30'h0, mem_byte_enable}, {30'h0, v.xbe});
               if (v.op[0])
                  chk({v.name, "_wdata"}, {16'h0, mem_wdata}, {16'h0, v.xwdata});
            end
            if (!v.no_resp && pcyc == ((phase == 0) ? v.w0 : v.w1) + 1) begin
               mem_resp  = 1'b1;
               mem_rdata = (phase == 0) ? v.d0 : v.d1;
               phase++;
               pcyc = 0;
            end
         end
         if (rsp_valid) break;
         if (lat > 40) begin
            chk({v.name, "_rsp_timeout"}, 32'd1, 32'd0);
            break;
         end
         @(posedge clk);
         #1;
         mem_resp  = 1'b0;
         mem_rdata = 16'hDEAD;
      end
      chk({v.name, "_latency"}, lat, v.xlat);
      chk({v.name, "_strobes"}, strobes, v.xstrobes);
      @(negedge clk);
      chk({v.name, "_pulse1"}, {31'h0, rsp_valid}, 32'd0);
      chk({v.name, "_ready_back"}, {31'h0, req_ready}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_indirect = 1'b0;
      req_sext = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
      mem_rdata = 16'hDEAD; mem_resp = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rst_rsp_error", {31'h0, rsp_error}, 32'd0);
      chk("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
      chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'd0);
      chk("rst_mem_out", {mem_address, mem_wdata}, 32'd0);
      chk("rst_be", {30'h0, mem_byte_enable}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      //        name       op ind sx addr     wdata    d0       w0 d1       w1 nr chk xaddr    xwdata   xbe    xrdata   xe lat s
      vecs.push_back(mk("wld",     2'd0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 16'h0000, 0, 0, 1, 16'h0010, 16'h0000, 2'b11, 16'hBEEF, 0, 2, 1));
      vecs.push_back(mk("bld_sx",  2'd2, 0, 1, 16'h0011, 16'h0000, 16'h80FF, 0, 16'h0000, 0, 0, 1, 16'h0010, 16'h0000, 2'b11, 16'hFF80, 0, 2, 1));
      vecs.push_back(mk("bld_zx",  2'd2, 0, 0, 16'h0011, 16'h0000, 16'h80FF, 0, 16'h0000, 0, 0, 1, 16'h0010, 16'h0000, 2'b11, 16'h0080, 0, 2, 1));
      vecs.push_back(mk("bld_l0",  2'd2, 0, 1, 16'h0030, 16'h0000, 16'h12F0, 0, 16'h0000, 0, 0, 1, 16'h0030, 16'h0000, 2'b11, 16'hFFF0, 0, 2, 1));
      vecs.push_back(mk("bst",     2'd3, 0, 0, 16'h0021, 16'h00A5, 16'h0000, 3, 16'h0000, 0, 0, 1, 16'h0020, 16'hA5A5, 2'b10, 16'h0000, 0, 5, 4));
      vecs.push_back(mk("wst",     2'd1, 0, 0, 16'h0044, 16'h5A5A, 16'h0000, 1, 16'h0000, 0, 0, 1, 16'h0044, 16'h5A5A, 2'b11, 16'h0000, 0, 3, 2));
      vecs.push_back(mk("ind_wld", 2'd0, 1, 0, 16'h0100, 16'h0000, 16'h0204, 0, 16'h1234, 0, 0, 1, 16'h0204, 16'h0000, 2'b11, 16'h1234, 0, 3, 2));
      vecs.push_back(mk("ind_bad", 2'd0, 1, 0, 16'h0100, 16'h0000, 16'h0205, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 2, 1));
      vecs.push_back(mk("ind_bld", 2'd2, 1, 0, 16'h0100, 16'h0000, 16'h0207, 0, 16'hAB11, 0, 0, 1, 16'h0206, 16'h0000, 2'b11, 16'h00AB, 0, 3, 2));
      vecs.push_back(mk("mis_wst", 2'd1, 0, 0, 16'h0003, 16'h1111, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 1, 0));
      vecs.push_back(mk("mis_ind", 2'd2, 1, 0, 16'h0101, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 1, 0));
      vecs.push_back(mk("tmo",     2'd0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0040, 16'h0000, 2'b11, 16'h0000, 1, 5, 4));
      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset while a load is stalled in ACCESS: strobes must drop with no clock edge
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd0; req_indirect = 1'b0; req_addr = 16'h0050;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_read", {31'h0, mem_read}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_strobes", {30'h0, mem_read, mem_write}, 32'd0);
      chk("async_rst_ready", {31'h0, req_ready}, 32'd1);
      chk("async_rst_rsp", {31'h0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_vec(vecs[0]);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
